// File: rtl/mux2_arbiter.sv
// Round-robin arbiter sharing a registered 2-to-1 mux between requesters A and B.
// Optional build macro ARB_TIMEOUT_EN adds MAX_HOLD-cycle preemption of the owner.
module mux2_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_last;      // 1 = B granted most recently
  logic               r_sel;
  logic [WIDTH-1:0]   r_y;
  logic               r_y_valid;
  logic               w_timeout;
  logic               w_sel_next;
  logic               w_load;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  logic [7:0] r_hold_cnt;

  assign w_timeout = (r_hold_cnt == HOLD_LIMIT);

  // Parks at HOLD_LIMIT so a late competitor preempts on its first waiting cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_hold_cnt <= 8'd0;
    end else if (w_state_next != IDLE && w_state_next != r_state) begin
      r_hold_cnt <= 8'd0;
    end else if (r_state != IDLE && r_hold_cnt != HOLD_LIMIT) begin
      r_hold_cnt <= r_hold_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_a && req_b) w_state_next = r_last ? OWN_A : OWN_B;
        else if (req_a)     w_state_next = OWN_A;
        else if (req_b)     w_state_next = OWN_B;
      end
      OWN_A: begin
        if (req_a && !(w_timeout && req_b)) w_state_next = OWN_A;
        else if (req_b)                     w_state_next = OWN_B;
        else                                w_state_next = IDLE;
      end
      OWN_B: begin
        if (req_b && !(w_timeout && req_a)) w_state_next = OWN_B;
        else if (req_a)                     w_state_next = OWN_A;
        else                                w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_sel_next = (w_state_next == OWN_B);
  assign w_load     = (w_state_next == OWN_A && req_a) ||
                      (w_state_next == OWN_B && req_b);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_sel     <= 1'b0;
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_y_valid <= w_load;
      if (w_state_next != IDLE) begin
        r_sel  <= w_sel_next;
        r_last <= w_sel_next;
      end
      if (w_load) r_y <= w_sel_next ? data_b : data_a;
    end
  end

  assign gnt_a   = (r_state == OWN_A);
  assign gnt_b   = (r_state == OWN_B);
  assign sel     = r_sel;
  assign y       = r_y;
  assign y_valid = r_y_valid;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter: vector table plus hand-written
// handover, long-hold and mid-ownership reset sequences.
module tb_mux2_arbiter;

  logic       clk;
  logic       n_reset;
  logic       req_a;
  logic       req_b;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       gnt_a;
  logic       gnt_b;
  logic       sel;
  logic [7:0] y;
  logic       y_valid;

  int n_cmp;
  int n_fail;

  mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .req_a   (req_a),
    .req_b   (req_b),
    .data_a  (data_a),
    .data_b  (data_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .sel     (sel),
    .y       (y),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ra;
    logic       rb;
    logic [7:0] da;
    logic [7:0] db;
    logic       ga;
    logic       gb;
    logic       s;
    logic       v;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ra, input logic rb, input logic [7:0] da, input logic [7:0] db);
    req_a  = ra;
    req_b  = rb;
    data_a = da;
    data_b = db;
  endtask

  // Advance one edge, then sample away from it; grants must never overlap.
  task automatic step();
    @(posedge clk);
    #1;
    check("no_overlap", 32'(gnt_a & gnt_b), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    //          ra    rb    da     db     ga    gb    s     v     y
    vecs[0]  = '{1'b1, 1'b1, 8'h5A, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A}; // tie after reset -> A
    vecs[1]  = '{1'b0, 1'b1, 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C}; // direct handover to B
    vecs[2]  = '{1'b0, 1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C}; // idle, sel and y hold
    vecs[3]  = '{1'b1, 1'b1, 8'h77, 8'h88, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77}; // tie, last=B -> A
    vecs[4]  = '{1'b1, 1'b1, 8'h78, 8'h88, 1'b1, 1'b0, 1'b0, 1'b1, 8'h78}; // A holds, y tracks
    vecs[5]  = '{1'b0, 1'b0, 8'h78, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 8'h78};
    vecs[6]  = '{1'b1, 1'b1, 8'h99, 8'h66, 1'b0, 1'b1, 1'b1, 1'b1, 8'h66}; // tie, last=A -> B
    vecs[7]  = '{1'b0, 1'b0, 8'h99, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC3}; // only B after B grant
    vecs[9]  = '{1'b1, 1'b1, 8'hA5, 8'hC4, 1'b0, 1'b1, 1'b1, 1'b1, 8'hC4}; // B keeps ownership
    vecs[10] = '{1'b1, 1'b0, 8'hA5, 8'hC4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5}; // handover to A
    vecs[11] = '{1'b0, 1'b0, 8'hA5, 8'hC4, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[12] = '{1'b0, 1'b0, 8'hFF, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}; // idle ignores data
    vecs[13] = '{1'b1, 1'b0, 8'hA5, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5}; // single requester
    vecs[14] = '{1'b0, 1'b0, 8'h00, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}; // release keeps y

    n_reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    check("rst_gnt_a",   32'(gnt_a),   32'd0);
    check("rst_gnt_b",   32'(gnt_b),   32'd0);
    check("rst_sel",     32'(sel),     32'd0);
    check("rst_y",       32'(y),       32'd0);
    check("rst_y_valid", 32'(y_valid), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].da, vecs[i].db);
      step();
      check($sformatf("vec%0d", i),
            32'({gnt_a, gnt_b, sel, y_valid, y}),
            32'({vecs[i].ga, vecs[i].gb, vecs[i].s, vecs[i].v, vecs[i].y}));
    end

    // Back-to-back handover A -> B with no gap cycle (last=A here).
    drive(1'b1, 1'b0, 8'h11, 8'h22);
    step();
    check("ho_own_a", 32'({gnt_a, gnt_b}), 32'b10);
    drive(1'b1, 1'b1, 8'h11, 8'h22);
    step();
    check("ho_a_keeps", 32'({gnt_a, gnt_b}), 32'b10);
    drive(1'b0, 1'b1, 8'h11, 8'h22);
    step();
    check("ho_gnt_b", 32'({gnt_a, gnt_b, sel}), 32'b011);
    check("ho_y", 32'(y), 32'h22);
    drive(1'b0, 1'b0, 8'h11, 8'h22);
    step();
    check("ho_release", 32'({gnt_a, gnt_b, y_valid}), 32'b000);

    // Long hold with both requesting; last=B so A wins the tie.
    drive(1'b1, 1'b1, 8'h33, 8'h44);
    step();
    for (int i = 0; i < 20; i++) begin
`ifdef ARB_TIMEOUT_EN
      check($sformatf("hold%0d", i), 32'({gnt_a, gnt_b}),
            ((i / 4) % 2 == 0) ? 32'b10 : 32'b01);
`else
      check($sformatf("hold%0d", i), 32'({gnt_a, gnt_b}), 32'b10);
`endif
      step();
    end
    drive(1'b0, 1'b0, 8'h33, 8'h44);
    step();
    check("hold_release", 32'({gnt_a, gnt_b}), 32'b00);

    // Reset asserted mid-ownership drops everything without waiting for an edge.
    drive(1'b0, 1'b1, 8'h55, 8'h66);
    step();
    check("mr_gnt_b", 32'({gnt_a, gnt_b, sel}), 32'b011);
    #2;
    n_reset = 1'b0;
    #1;
    check("mr_gnt_a",   32'(gnt_a),   32'd0);
    check("mr_gnt_b0",  32'(gnt_b),   32'd0);
    check("mr_sel",     32'(sel),     32'd0);
    check("mr_y",       32'(y),       32'd0);
    check("mr_y_valid", 32'(y_valid), 32'd0);
    drive(1'b1, 1'b1, 8'h5C, 8'h6D);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    check("mr_restart", 32'({gnt_a, gnt_b, sel, y_valid}), 32'b1001);
    check("mr_restart_y", 32'(y), 32'h5C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
